sync_fifo: RTL and testbench

- Single-clock synchronous FIFO with a registered read port, write acknowledge, and occupancy status flags.
- Flags: full, almostfull, empty, almostempty, overflow, underflow.
- Generic buffering block between a producer and a consumer in the same clock domain.
- Its reset state is checked continuously by system-level assertions.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/sync_fifo.sv | 89 ++++++++
 tb/tb_sync_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry and pointer width.
package fifo_pkg;

   localparam int DEF_FIFO_WIDTH = 16;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int FIFO_PTR_W     = $clog2(DEF_FIFO_DEPTH);

endpackage : fifo_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port, write acknowledge and occupancy flags.
// Pointers wrap naturally because the depth is a power of two.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  almostfull,
   output logic                  empty,
   output logic                  almostempty
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [FIFO_WIDTH-1:0] r_data_out;
   logic                  r_wr_ack;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_wr_ok;
   logic w_rd_ok;

   // Acceptance is judged on the flags as they stood before this edge.
   assign w_wr_ok = wr_en && !full;
   assign w_rd_ok = rd_en && !empty;

   // NOTE: storage has no reset; after reset the pointers make stale words unreachable.
   always_ff @(posedge clk) begin
      if (w_wr_ok) r_mem[r_wr_ptr] <= data_in;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_data_out  <= '0;
         r_wr_ack    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wr_ack    <= w_wr_ok;
         r_overflow  <= wr_en && full;
         r_underflow <= rd_en && empty;

         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);

         if (w_rd_ok) begin
            r_data_out <= r_mem[r_rd_ptr];
            r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
         end

         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign data_out    = r_data_out;
   assign wr_ack      = r_wr_ack;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;

   assign full        = (r_count == DEPTH_C);
   assign almostfull  = (r_count == DEPTH_C - CNT_W'(1));
   assign empty       = (r_count == '0);
   assign almostempty = (r_count == CNT_W'(1));

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_sync_fifo;
   import fifo_pkg::*;

   localparam int W = DEF_FIFO_WIDTH;
   localparam int D = DEF_FIFO_DEPTH;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] data_in;
   logic         wr_en;
   logic         rd_en;
   logic [W-1:0] data_out;
   logic         wr_ack, overflow, underflow;
   logic         full, almostfull, empty, almostempty;

   sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .wr_ack      (wr_ack),
      .overflow    (overflow),
      .underflow   (underflow),
      .full        (full),
      .almostfull  (almostfull),
      .empty       (empty),
      .almostempty (almostempty)
   );

   always #5 clk = ~clk;

   // Reference model: queue of stored words plus the expected registered outputs.
   logic [W-1:0] q[$];
   logic [W-1:0] exp_dout;
   logic         exp_ack, exp_ovf, exp_udf;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      check({tag, ".data_out"},    32'(data_out),    32'(exp_dout));
      check({tag, ".wr_ack"},      32'(wr_ack),      32'(exp_ack));
      check({tag, ".overflow"},    32'(overflow),    32'(exp_ovf));
      check({tag, ".underflow"},   32'(underflow),   32'(exp_udf));
      check({tag, ".full"},        32'(full),        32'(n == D));
      check({tag, ".almostfull"},  32'(almostfull),  32'(n == D - 1));
      check({tag, ".empty"},       32'(empty),       32'(n == 0));
      check({tag, ".almostempty"}, 32'(almostempty), 32'(n == 1));
   endtask

   task automatic model_reset();
      q.delete();
      exp_dout = '0;
      exp_ack  = 1'b0;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
   endtask

   // One clock with the given request; the model applies the FIFO rules to its pre-edge occupancy.
   task automatic cycle(input logic w, input logic r, input logic [W-1:0] d, input string tag);
      bit wr_ok, rd_ok;
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      @(posedge clk);
      wr_ok   = w && (q.size() < D);
      rd_ok   = r && (q.size() > 0);
      exp_ack = wr_ok;
      exp_ovf = w && !wr_ok;
      exp_udf = r && !rd_ok;
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset asserted between edges, held across one edge, then released.
   task automatic pulse_reset(input string tag);
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all({tag, ".async"});
      @(posedge clk);
      #1;
      check_all({tag, ".held"});
      rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] oldest;
      logic [W-1:0] d;
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      data_in = '0;
      model_reset();

      // Power-on reset
      #3;
      check_all("por");
      repeat (2) @(posedge clk);
      #1;
      check_all("por_held");
      rst_n = 1'b1;

      // Fill to full, then one rejected write
      for (int i = 1; i <= D; i++) begin
         cycle(1'b1, 1'b0, W'(i), "fill");
         check("fill.wr_ack_1", 32'(wr_ack), 32'd1);
         if (i == D - 1) check("fill.almostfull_at_7", 32'(almostfull), 32'd1);
      end
      check("fill.full_at_8", 32'(full), 32'd1);
      cycle(1'b1, 1'b0, 16'hDEAD, "ovf");
      check("ovf.overflow", 32'(overflow), 32'd1);
      check("ovf.wr_ack", 32'(wr_ack), 32'd0);

      // Drain in order, then one rejected read
      for (int i = 1; i <= D; i++) begin
         cycle(1'b0, 1'b1, '0, "drain");
         check("drain.order", 32'(data_out), 32'(i));
         if (i == D - 1) check("drain.almostempty", 32'(almostempty), 32'd1);
      end
      check("drain.empty", 32'(empty), 32'd1);
      cycle(1'b0, 1'b1, '0, "udf");
      check("udf.underflow", 32'(underflow), 32'd1);
      check("udf.data_hold", 32'(data_out), 32'h0008);

      // Simultaneous read/write at empty: write only, no bypass
      cycle(1'b1, 1'b1, 16'hABCD, "rw_empty");
      check("rw_empty.underflow", 32'(underflow), 32'd1);
      check("rw_empty.wr_ack", 32'(wr_ack), 32'd1);
      check("rw_empty.almostempty", 32'(almostempty), 32'd1);
      check("rw_empty.no_bypass", 32'(data_out), 32'h0008);

      // Simultaneous at full: read only
      for (int i = 0; i < D - 1; i++) cycle(1'b1, 1'b0, W'(16'h0010 + i), "refill");
      cycle(1'b1, 1'b1, 16'hEEEE, "rw_full");
      check("rw_full.overflow", 32'(overflow), 32'd1);
      check("rw_full.oldest", 32'(data_out), 32'hABCD);
      check("rw_full.almostfull", 32'(almostfull), 32'd1);

      // Simultaneous at count 4: both accepted
      repeat (3) cycle(1'b0, 1'b1, '0, "to4");
      oldest = q[0];
      cycle(1'b1, 1'b1, 16'h4444, "rw_mid");
      check("rw_mid.wr_ack", 32'(wr_ack), 32'd1);
      check("rw_mid.oldest", 32'(data_out), 32'(oldest));
      check("rw_mid.count4", 32'(q.size()), 32'd4);

      // Reset mid-traffic with five entries stored
      cycle(1'b1, 1'b0, 16'h5555, "to5");
      wr_en = 1'b1;
      rd_en = 1'b1;
      pulse_reset("mid_rst");
      cycle(1'b0, 1'b1, '0, "post_rst_rd");
      check("post_rst.underflow", 32'(underflow), 32'd1);

      // Wrap-around: interleaved write/read pairs
      for (int i = 0; i < 20; i++) begin
         d = W'($urandom);
         cycle(1'b1, 1'b0, d, "wrap_wr");
         cycle(1'b0, 1'b1, '0, "wrap_rd");
         check("wrap.data", 32'(data_out), 32'(d));
      end

      // Randomized regression with occasional reset pulses
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(99) < 2) pulse_reset("rand_rst");
         else cycle(1'($urandom), 1'($urandom), W'($urandom), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_sync_fifo
